// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU datapath control sequencer.
package alu_ctrl_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int SEL_W    = 5;
  localparam int OPC_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    LOAD_A = 2'd2,
    EXEC   = 2'd3
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hF;

  // Instruction field bit positions
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RDEST_MSB = 11;
  localparam int RDEST_LSB = 8;
  localparam int OPEXT_MSB = 7;
  localparam int OPEXT_LSB = 4;
  localparam int RSRC_MSB  = 3;
  localparam int RSRC_LSB  = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  localparam logic [SEL_W-1:0] SEL_NONE = 5'd0;

  // Decoded instruction as held for the duration of one sequence
  typedef struct packed {
    logic [3:0]        rdest;
    logic [3:0]        rsrc;
    logic              is_rtype;
    logic              no_wb;
    logic [OPC_W-1:0]  alu_opcode;
    logic [DATA_W-1:0] imm_ext;
  } instr_fields_t;

  // Register n is selected by value n+1; 0 means no register
  function automatic logic [SEL_W-1:0] reg_sel(input logic [3:0] r);
    return SEL_W'(r) + SEL_W'(1);
  endfunction

endpackage

// File: rtl/alu_datapath_ctrl_if.sv
// Instruction handshake plus datapath control bundle.
interface alu_datapath_ctrl_if;
  import alu_ctrl_pkg::*;

  logic [15:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                done;
  logic [DATA_W-1:0]   immediate;
  logic                imm_control;
  logic [SEL_W-1:0]    control1;
  logic [SEL_W-1:0]    control2;
  logic [OPC_W-1:0]    opcode;
  logic                buff_en;
  logic [NUM_REGS-1:0] enable;

  // Sequencer side: takes instructions, drives the datapath controls
  modport master (
    input  instr, instr_valid,
    output instr_ready, done, immediate, imm_control,
           control1, control2, opcode, buff_en, enable
  );

  // Instruction source / datapath side
  modport slave (
    output instr, instr_valid,
    input  instr_ready, done, immediate, imm_control,
           control1, control2, opcode, buff_en, enable
  );
endinterface

// File: rtl/alu_instr_decode.sv
// Combinational decode of a 16-bit instruction word.
module alu_instr_decode
  import alu_ctrl_pkg::*;
(
  input  logic [15:0]       instr,
  output logic              is_rtype,
  output logic              is_nop,
  output logic              no_wb,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] imm_ext,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc
);
  logic [3:0] op;
  logic [3:0] opext;
  logic [7:0] imm8;

  assign op    = instr[OP_MSB:OP_LSB];
  assign opext = instr[OPEXT_MSB:OPEXT_LSB];
  assign imm8  = instr[IMM_MSB:IMM_LSB];
  assign rdest = instr[RDEST_MSB:RDEST_LSB];
  assign rsrc  = instr[RSRC_MSB:RSRC_LSB];

  // Classify the word and build ALU opcode and sign-extended immediate
  always_comb begin
    is_rtype   = (op == OP_RTYPE);
    is_nop     = (op == OP_NOP);
    // CMP and CMPI share the same code in opext / op respectively
    no_wb      = is_rtype ? (opext == OP_CMP) : (!is_nop && op == OP_CMP);
    alu_opcode = is_rtype ? {4'h0, opext} : {op, 4'h0};
    imm_ext    = {{(DATA_W-8){imm8[7]}}, imm8};
  end
endmodule

// File: rtl/alu_datapath_ctrl.sv
// Three-step sequencer: load B, load A, execute/write back.
module alu_datapath_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  alu_datapath_ctrl_if.master bus
);
  state_e              state_q, state_d;
  instr_fields_t       fields_q, fields_d;
  instr_fields_t       dec_fields;
  logic                dec_is_nop;
  logic                accept;

  logic [DATA_W-1:0]   immediate_q, immediate_d;
  logic                imm_control_q, imm_control_d;
  logic [SEL_W-1:0]    control1_q, control1_d;
  logic [SEL_W-1:0]    control2_q, control2_d;
  logic [OPC_W-1:0]    opcode_q, opcode_d;
  logic                buff_en_q, buff_en_d;
  logic [NUM_REGS-1:0] enable_q, enable_d;
  logic                done_q, done_d;

  alu_instr_decode u_decode (
    .instr      (bus.instr),
    .is_rtype   (dec_fields.is_rtype),
    .is_nop     (dec_is_nop),
    .no_wb      (dec_fields.no_wb),
    .alu_opcode (dec_fields.alu_opcode),
    .imm_ext    (dec_fields.imm_ext),
    .rdest      (dec_fields.rdest),
    .rsrc       (dec_fields.rsrc)
  );

  assign accept = bus.instr_valid && (state_q == IDLE);

  // Next state, instruction latch and the registered output values
  always_comb begin
    state_d       = state_q;
    fields_d      = fields_q;
    immediate_d   = '0;
    imm_control_d = 1'b0;
    control1_d    = SEL_NONE;
    control2_d    = SEL_NONE;
    opcode_d      = '0;
    buff_en_d     = 1'b0;
    enable_d      = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          fields_d = dec_fields;
          if (!dec_is_nop) state_d = LOAD_B;
        end
      end
      LOAD_B:  state_d = LOAD_A;
      LOAD_A:  state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the state being entered so they are
    // valid from a flop for the whole cycle spent in that state
    case (state_d)
      LOAD_B: begin
        if (fields_d.is_rtype) begin
          control2_d = reg_sel(fields_d.rsrc);
        end else begin
          imm_control_d = 1'b1;
          immediate_d   = fields_d.imm_ext;
        end
      end
      LOAD_A: control1_d = reg_sel(fields_d.rdest);
      EXEC: begin
        opcode_d  = fields_d.alu_opcode;
        buff_en_d = 1'b1;
        if (!fields_d.no_wb) enable_d = NUM_REGS'(1) << fields_d.rdest;
      end
      default: ;
    endcase

    // A NOP completes in the cycle right after it is taken
    done_d = (state_d == EXEC) || (accept && dec_is_nop);
  end

  // State, latch and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      fields_q      <= '0;
      immediate_q   <= '0;
      imm_control_q <= 1'b0;
      control1_q    <= SEL_NONE;
      control2_q    <= SEL_NONE;
      opcode_q      <= '0;
      buff_en_q     <= 1'b0;
      enable_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fields_q      <= fields_d;
      immediate_q   <= immediate_d;
      imm_control_q <= imm_control_d;
      control1_q    <= control1_d;
      control2_q    <= control2_d;
      opcode_q      <= opcode_d;
      buff_en_q     <= buff_en_d;
      enable_q      <= enable_d;
      done_q        <= done_d;
    end
  end

  assign bus.instr_ready = (state_q == IDLE);
  assign bus.done        = done_q;
  assign bus.immediate   = immediate_q;
  assign bus.imm_control = imm_control_q;
  assign bus.control1    = control1_q;
  assign bus.control2    = control2_q;
  assign bus.opcode      = opcode_q;
  assign bus.buff_en     = buff_en_q;
  assign bus.enable      = enable_q;
endmodule

// File: tb/tb_alu_datapath_ctrl.sv
// Randomized and directed bench for alu_datapath_ctrl against a cycle model.
module tb_alu_datapath_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_datapath_ctrl_if bus ();

  alu_datapath_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: how many steps into the sequence we are (0 = idle),
  // which instruction is in flight, and whether a NOP was just taken
  int          m_step = 0;
  logic [15:0] m_instr = '0;
  logic        m_nop_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_edge();
    m_nop_done = 1'b0;
    if (!reset) begin
      m_step = 0;
    end else if (m_step == 0) begin
      if (bus.instr_valid) begin
        $display("txn accept instr=%h at %0t", bus.instr, $time);
        if (bus.instr[15:12] == 4'hF) begin
          m_nop_done = 1'b1;
        end else begin
          m_step  = 1;
          m_instr = bus.instr;
        end
      end
    end else begin
      m_step = (m_step == 3) ? 0 : m_step + 1;
    end
  endtask

  // Compare every output to what the instruction rules say for this step
  task automatic check_outputs();
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        ext;
    logic signed [7:0] imm8;
    logic [15:0]       e_imm;
    logic              e_immc;
    logic [4:0]        e_c1;
    logic [4:0]        e_c2;
    logic [7:0]        e_opc;
    logic              e_buf;
    logic [15:0]       e_en;
    logic              rtype;
    logic              cmp;
    op    = m_instr[15:12];
    rd    = m_instr[11:8];
    ext   = m_instr[7:4];
    rs    = m_instr[3:0];
    imm8  = m_instr[7:0];
    rtype = (op == 4'h0);
    cmp   = rtype ? (ext == 4'hB) : (op == 4'hB);
    e_imm = '0; e_immc = 1'b0; e_c1 = '0; e_c2 = '0;
    e_opc = '0; e_buf = 1'b0; e_en = '0;
    if (m_step == 1) begin
      if (rtype) e_c2 = 5'(rs) + 5'd1;
      else begin
        e_immc = 1'b1;
        e_imm  = 16'(imm8);
      end
    end
    if (m_step == 2) e_c1 = 5'(rd) + 5'd1;
    if (m_step == 3) begin
      e_opc = rtype ? 8'(ext) : 8'(op) * 8'd16;
      e_buf = 1'b1;
      e_en  = cmp ? 16'h0 : 16'(2 ** rd);
    end
    check("instr_ready", 32'(bus.instr_ready), 32'(m_step == 0));
    check("done",        32'(bus.done),        32'((m_step == 3) || m_nop_done));
    check("immediate",   32'(bus.immediate),   32'(e_imm));
    check("imm_control", 32'(bus.imm_control), 32'(e_immc));
    check("control1",    32'(bus.control1),    32'(e_c1));
    check("control2",    32'(bus.control2),    32'(e_c2));
    check("opcode",      32'(bus.opcode),      32'(e_opc));
    check("buff_en",     32'(bus.buff_en),     32'(e_buf));
    check("enable",      32'(bus.enable),      32'(e_en));
  endtask

  task automatic cycle(input logic rst_n, input logic valid, input logic [15:0] ins);
    reset           = rst_n;
    bus.instr_valid = valid;
    bus.instr       = ins;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    reset           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    // Reset for two edges, then release
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_done",  32'(bus.done),        32'd0);

    // ADDI r3, -2
    cycle(1'b1, 1'b1, 16'h13FE);
    check("addi_immc", 32'(bus.imm_control), 32'd1);
    check("addi_imm",  32'(bus.immediate),   32'h0000FFFE);
    check("addi_busy", 32'(bus.instr_ready), 32'd0);
    cycle(1'b1, 1'b0, 16'h0);
    check("addi_c1",   32'(bus.control1),    32'd4);
    cycle(1'b1, 1'b0, 16'h0);
    check("addi_opc",  32'(bus.opcode),      32'h10);
    check("addi_en",   32'(bus.enable),      32'h0008);
    check("addi_done", 32'(bus.done),        32'd1);
    cycle(1'b1, 1'b0, 16'h0);

    // R-type r5 op r2, instr changes while busy
    cycle(1'b1, 1'b1, 16'h0512);
    check("r_c2",   32'(bus.control2),    32'd3);
    check("r_immc", 32'(bus.imm_control), 32'd0);
    cycle(1'b1, 1'b1, 16'hFFFF);
    check("r_c1",   32'(bus.control1),    32'd6);
    cycle(1'b1, 1'b1, 16'h1234);
    check("r_opc",  32'(bus.opcode),      32'h01);
    check("r_en",   32'(bus.enable),      32'h0020);
    cycle(1'b1, 1'b0, 16'h0);

    // CMP: no writeback
    cycle(1'b1, 1'b1, 16'h07B1);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    check("cmp_opc",  32'(bus.opcode),  32'h0B);
    check("cmp_en",   32'(bus.enable),  32'h0);
    check("cmp_buf",  32'(bus.buff_en), 32'd1);
    cycle(1'b1, 1'b0, 16'h0);

    // NOP, then ADDI held valid: one accept per four cycles
    cycle(1'b1, 1'b1, 16'hF000);
    check("nop_done", 32'(bus.done),  32'd1);
    check("nop_buf",  32'(bus.buff_en), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 16'h13FE);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0);

    // Reset during LOAD_A discards the instruction
    cycle(1'b1, 1'b1, 16'h0512);
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    check("mid_rst_c1", 32'(bus.control1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 16'h0);
      check("mid_rst_en",   32'(bus.enable), 32'h0);
      check("mid_rst_done", 32'(bus.done),   32'd0);
    end

    // Random traffic, including boundary registers and occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ins;
      int          r;
      ins = 16'($urandom);
      r   = int'($urandom_range(0, 9));
      if (r == 0) ins[15:12] = 4'hF;
      if (r == 1) ins[15:12] = 4'h0;
      if (r == 2) ins[11:8]  = 4'hF;
      if (r == 3) ins[3:0]   = 4'hF;
      if (r == 4) ins[7:4]   = 4'hB;
      cycle(($urandom_range(0, 49) != 0), 1'($urandom), ins);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_datapath_ctrl.md
Name: alu_datapath_ctrl

Overview:
- Control sequencer that drives the ALUDataPath control interface; it is the initiator end of the interface that ALUDataPath responds to.
- Accepts one 16-bit instruction word per valid/ready handshake.
- Decodes the word and issues the three-step datapath sequence: load operand B, load operand A, execute and write back. Each step drives the buff_en/enable/control1/control2/imm_control/opcode/immediate bundle for one cycle.
- Sits between the instruction source (fetch stage or testbench) and ALUDataPath.

Parameters:
- DATA_W, 16, datapath word width and immediate width.
- NUM_REGS, 16, register count; width of the one-hot enable bus.
- SEL_W, 5, width of control1/control2; select value 0 = none, value n+1 = register n.
- OPC_W, 8, ALU opcode width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- instr  in  16  instruction: [15:12] op, [11:8] rdest, [7:4] opext, [3:0] rsrc; [7:0] is imm8 for I-type
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller can accept instr (IDLE)
- done  out  1  one-cycle pulse when an instruction completes
- immediate  out  DATA_W  immediate value to the datapath
- imm_control  out  1  selects immediate as ALU operand B
- control1  out  SEL_W  operand A register select
- control2  out  SEL_W  operand B register select
- opcode  out  OPC_W  ALU opcode
- buff_en  out  1  drives ALU result onto the bus
- enable  out  NUM_REGS  one-hot register write enable

Behaviour:
- Reset is synchronous and active-low: on a clk edge with reset==0, state goes to IDLE and every output is 0 except instr_ready.
- instr_ready is 1 in the first cycle after reset deasserts. The instruction latch is cleared.
- All datapath outputs are registered (Moore). In any state other than the one that drives a signal, that signal is 0.
- States: IDLE, LOAD_B, LOAD_A, EXEC.
- instr_ready = (state==IDLE).
- An instruction is accepted on an edge where instr_valid && instr_ready. The decoded fields are latched at that edge.
- Decode:
  - op==4'h0 is R-type. Operand B comes from register rsrc. ALU opcode = {4'h0, opext}.
  - op==4'hF is NOP.
  - Any other op is I-type. immediate = sign-extend(imm8) to DATA_W. ALU opcode = {op, 4'h0}.
- No-writeback instructions: R-type with opext==4'hB (CMP) and I-type with op==4'hB (CMPI).
- Transitions:
  - IDLE goes to LOAD_B on accept of a non-NOP instruction.
  - NOP: state stays IDLE, no datapath activity, and done pulses in the cycle after acceptance.
  - LOAD_B goes to LOAD_A, LOAD_A goes to EXEC, EXEC goes to IDLE, each unconditionally.
- LOAD_B outputs:
  - I-type: imm_control=1 and immediate=sext(imm8).
  - R-type: control2 = rsrc+1.
- LOAD_A output: control1 = rdest+1. Operand A is always rdest (two-address form).
- EXEC outputs:
  - opcode = decoded ALU opcode and buff_en=1.
  - enable = 1<<rdest, or 0 for no-writeback instructions.
  - done=1.
- Latency: 3 cycles from the accept edge to done. Accept edge at cycle N gives LOAD_B in N+1, LOAD_A in N+2, EXEC and done in N+3.
- Back-to-back: instr_valid held high gives one accept per 4 cycles. The next accept happens in the IDLE cycle after EXEC.
- instr_valid while busy is ignored. instr may change while busy without affecting the latched instruction.
- Reset mid-operation discards the in-flight instruction. done does not pulse, and no enable bit is asserted after the reset edge.
- At most one enable bit is set in any cycle. buff_en is 1 only in EXEC.
- rdest/rsrc = 15 gives select 16 (5'b10000). No wrap-around occurs at SEL_W=5.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - state enum (IDLE, LOAD_B, LOAD_A, EXEC)
  - op constants: OP_RTYPE=4'h0, OP_CMP=4'hB, OP_NOP=4'hF
  - instruction field bit positions
  - SEL_NONE=5'd0
- One natural sub-module: alu_instr_decode. It is purely combinational: instr in; is_rtype, is_nop, no_wb, alu_opcode, imm_ext out. The FSM and output registers stay in alu_datapath_ctrl.

Test Plan:
- Reset held low for 2 edges, then released → all outputs 0, instr_ready=1, done=0.
- I-type ADDI r3, imm8=0xFE (instr=16'h13FE), instr_valid for 1 cycle → LOAD_B: imm_control=1, immediate=16'hFFFE. LOAD_A: control1=5'd4. EXEC: opcode=8'h10, buff_en=1, enable=16'h0008, done=1, exactly 3 cycles after the accept edge.
- R-type r5 op r2 with opext=4'h1 (instr=16'h0512) → LOAD_B: control2=5'd3, imm_control=0. LOAD_A: control1=5'd6. EXEC: opcode=8'h01, enable=16'h0020.
- CMP (instr=16'h07B1) → EXEC: buff_en=1, opcode=8'h0B, enable=16'h0000, done=1.
- NOP (16'hF000) followed by instr_valid held high with 16'h13FE → done pulses 1 cycle after the NOP accept with no datapath activity. After that, 16'h13FE is accepted once per 4 cycles. instr_ready=0 in LOAD_B/LOAD_A/EXEC.
- reset=0 asserted during LOAD_A of 16'h0512 → the next edge gives IDLE and all outputs 0. enable is never nonzero and done never pulses for that instruction.
